// File: rtl/shmem_client_if.sv
// Command/response and arbiter-port bundle for shmem_client.
// master = local master plus arbiter side, slave = the client adapter.
interface shmem_client_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wren;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  busy;
  logic                  shmem_request;
  logic                  shmem_wren;
  logic [ADDR_WIDTH-1:0] shmem_addr;
  logic [DATA_WIDTH-1:0] shmem_datain;
  logic [DATA_WIDTH-1:0] shmem_dataout;
  logic                  shmem_done;

  modport master (
    output cmd_valid, cmd_wren, cmd_addr, cmd_data,
    output shmem_dataout, shmem_done,
    input  cmd_ready, rsp_valid, rsp_data, busy,
    input  shmem_request, shmem_wren,
    input  shmem_addr, shmem_datain
  );

  modport slave (
    input  cmd_valid, cmd_wren, cmd_addr, cmd_data,
    input  shmem_dataout, shmem_done,
    output cmd_ready, rsp_valid, rsp_data, busy,
    output shmem_request, shmem_wren,
    output shmem_addr, shmem_datain
  );
endinterface

// File: rtl/shmem_client.sv
// Initiator adapter for one shared-memory arbiter port:
// command FIFO, one-at-a-time request FSM, fixed-latency read return.
module shmem_client #(
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int LOG2_FIFO_DEPTH = 2,
  parameter int READ_LATENCY    = 1
) (
  input  logic           clk,
  input  logic           srst,
  shmem_client_if.slave  bus
);

  typedef struct packed {
    logic                  wren;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } cmd_t;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  localparam logic [LOG2_FIFO_DEPTH:0] FULL_CNT =
    (LOG2_FIFO_DEPTH+1)'(FIFO_DEPTH);

  cmd_t                     mem [FIFO_DEPTH];
  logic [LOG2_FIFO_DEPTH-1:0] wr_ptr;
  logic [LOG2_FIFO_DEPTH-1:0] rd_ptr;
  logic [LOG2_FIFO_DEPTH:0]   count;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     drop;
  cmd_t                     head;

  state_t                   state;
  state_t                   state_n;
  logic                     req_q;
  logic                     wren_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    data_q;

  logic                     read_ret;
  logic                     cap;
  logic                     pend;
  logic                     rsp_valid_q;
  logic [DATA_WIDTH-1:0]    rsp_data_q;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.cmd_valid && !full;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{bus.cmd_wren, bus.cmd_addr, bus.cmd_data};
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    drop    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (bus.shmem_done) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            drop    = 1'b1;
            state_n = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      wren_q <= 1'b0;
    end else begin
      state <= state_n;
      if (pop) begin
        req_q  <= 1'b1;
        wren_q <= head.wren;
      end else if (drop) begin
        req_q  <= 1'b0;
        wren_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      addr_q <= head.addr;
      data_q <= head.data;
    end
  end

  // A read retires on the done cycle; its data lands READ_LATENCY later.
  assign read_ret = (state == REQ) && bus.shmem_done && !wren_q;

  generate
    if (READ_LATENCY == 0) begin : g_lat0
      assign cap  = read_ret;
      assign pend = 1'b0;
    end else begin : g_latn
      logic [READ_LATENCY-1:0] pipe;
      always_ff @(posedge clk) begin
        if (srst) pipe <= '0;
        else      pipe <= (pipe << 1) | READ_LATENCY'(read_ret);
      end
      assign cap  = pipe[READ_LATENCY-1];
      assign pend = |pipe;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) rsp_valid_q <= 1'b0;
    else      rsp_valid_q <= cap;
  end

  always_ff @(posedge clk) begin
    if (cap) rsp_data_q <= bus.shmem_dataout;
  end

  assign bus.cmd_ready     = !full;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.busy          = !empty || req_q || pend;
  assign bus.shmem_request = req_q;
  assign bus.shmem_wren    = wren_q;
  assign bus.shmem_addr    = addr_q;
  assign bus.shmem_datain  = data_q;

endmodule

// File: tb/tb_shmem_client.sv
// Bench for shmem_client: directed scenarios then random traffic,
// checked every cycle against a queue-based transaction model.
module tb_shmem_client;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int RL = 1;

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } mcmd_t;

  logic clk;
  logic srst;

  shmem_client_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  shmem_client #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .LOG2_FIFO_DEPTH(2),
    .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .srst(srst),
    .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_acc = 0;
  bit chk_en = 0;

  mcmd_t         fq[$];
  mcmd_t         bcmd;
  bit            bus_v = 0;
  int            rq[$];
  logic [DW-1:0] hist [16];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check outputs against the model, apply inputs, advance model.
  task automatic drv(bit vv, bit ww, logic [AW-1:0] aa,
                     logic [DW-1:0] dd, bit dn,
                     logic [DW-1:0] dout, bit rs);
    bit ready_e;
    bit rsp_e;
    bit pend;
    @(negedge clk);
    ready_e = fq.size() < DEPTH;
    rsp_e = rq.size() > 0 && rq[0] == cyc;
    pend = 0;
    foreach (rq[i]) if (cyc >= rq[i] - RL && cyc < rq[i]) pend = 1;
    if (chk_en) begin
      chk("request", ifc.shmem_request, bus_v);
      if (bus_v) begin
        chk("wren", ifc.shmem_wren, bcmd.w);
        chk("addr", ifc.shmem_addr, bcmd.a);
        chk("datain", ifc.shmem_datain, bcmd.d);
      end
      chk("cmd_ready", ifc.cmd_ready, ready_e);
      chk("rsp_valid", ifc.rsp_valid, rsp_e);
      if (rsp_e) chk("rsp_data", ifc.rsp_data, hist[(cyc-1)%16]);
      chk("busy", ifc.busy, fq.size() > 0 || bus_v || pend);
    end
    if (rsp_e) void'(rq.pop_front());
    ifc.cmd_valid     = vv;
    ifc.cmd_wren      = ww;
    ifc.cmd_addr      = aa;
    ifc.cmd_data      = dd;
    ifc.shmem_done    = dn;
    ifc.shmem_dataout = dout;
    srst              = rs;
    hist[cyc%16]      = dout;
    if (bus_v && dn) begin
      if (!bcmd.w) rq.push_back(cyc + RL + 1);
      if (fq.size() > 0) bcmd = fq.pop_front();
      else bus_v = 0;
    end else if (!bus_v && fq.size() > 0) begin
      bcmd = fq.pop_front();
      bus_v = 1;
    end
    if (vv && ready_e) begin
      fq.push_back('{ww, aa, dd});
      if (!rs) n_acc++;
    end
    if (rs) begin
      fq.delete();
      rq.delete();
      bus_v = 0;
    end
    cyc++;
  endtask

  task automatic idle(int n, bit dn);
    for (int i = 0; i < n; i++) drv(0, 0, '0, '0, dn, $urandom, 0);
  endtask

  initial begin
    srst = 1'b1;
    ifc.cmd_valid = 0;
    ifc.cmd_wren = 0;
    ifc.cmd_addr = '0;
    ifc.cmd_data = '0;
    ifc.shmem_done = 0;
    ifc.shmem_dataout = '0;
    drv(0, 0, '0, '0, 0, '0, 1);
    drv(0, 0, '0, '0, 0, '0, 1);
    chk_en = 1;
    idle(2, 0);
    chk("rst_request", ifc.shmem_request, 0);
    chk("rst_ready", ifc.cmd_ready, 1);
    chk("rst_busy", ifc.busy, 0);

    // single write, done two cycles after request rises
    drv(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 0);
    drv(0, 0, '0, '0, 0, 0, 0);
    drv(0, 0, '0, '0, 0, 0, 0);
    chk("wr_req_up", ifc.shmem_request, 1);
    chk("wr_addr", ifc.shmem_addr, 12'h010);
    drv(0, 0, '0, '0, 0, 0, 0);
    drv(0, 0, '0, '0, 1, 0, 0);
    chk("wr_data_hold", ifc.shmem_datain, 32'hDEADBEEF);
    drv(0, 0, '0, '0, 0, 0, 0);
    chk("wr_req_down", ifc.shmem_request, 0);
    idle(3, 0);

    // single read with fixed return data
    drv(1, 0, 12'h123, '0, 0, 0, 0);
    drv(0, 0, '0, '0, 0, 0, 0);
    drv(0, 0, '0, '0, 1, 0, 0);
    drv(0, 0, '0, '0, 0, 32'hCAFEF00D, 0);
    drv(0, 0, '0, '0, 0, 0, 0);
    chk("rd_rsp_valid", ifc.rsp_valid, 1);
    chk("rd_rsp_data", ifc.rsp_data, 32'hCAFEF00D);
    drv(0, 0, '0, '0, 0, 0, 0);
    chk("rd_rsp_once", ifc.rsp_valid, 0);
    idle(2, 0);

    // burst to full with done held low, then drain one per cycle
    n_acc = 0;
    for (int i = 0; i < 6; i++)
      drv(1, i[0], AW'(i + 8), DW'(i * 3), 0, 0, 0);
    chk("burst_accepted", n_acc, 5);
    chk("burst_full", ifc.cmd_ready, 0);
    for (int i = 0; i < 6; i++) drv(0, 0, '0, '0, 1, $urandom, 0);
    idle(4, 0);

    // read/write/read back to back, done every cycle
    for (int i = 0; i < 8; i++) begin
      drv(i < 3, i == 1, AW'(i + 1), DW'(i), 1, (i < 4) ? 32'h1 : 32'h3, 0);
      if (i == 4) chk("mix_rsp1", ifc.rsp_data, 32'h1);
      if (i == 6) chk("mix_rsp2", ifc.rsp_data, 32'h3);
    end
    idle(3, 0);

    // reset with queued commands and a read in flight
    drv(1, 0, 12'h040, '0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drv(1, 1, AW'(i), DW'(i), 0, 0, 0);
    drv(0, 0, '0, '0, 1, 0, 0);
    drv(0, 0, '0, '0, 0, 32'h55, 1);
    drv(0, 0, '0, '0, 0, 0, 0);
    chk("srst_request", ifc.shmem_request, 0);
    chk("srst_ready", ifc.cmd_ready, 1);
    chk("srst_busy", ifc.busy, 0);
    drv(0, 0, '0, '0, 0, 0, 0);
    chk("srst_no_rsp", ifc.rsp_valid, 0);

    // spurious done while idle
    idle(4, 1);
    chk("spur_request", ifc.shmem_request, 0);
    chk("spur_busy", ifc.busy, 0);

    // random traffic
    for (int i = 0; i < 1500; i++)
      drv($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom),
          $urandom, $urandom_range(0, 1), $urandom,
          $urandom_range(0, 79) == 0);
    idle(8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
